// File: rtl/ffe_pkg.sv
// rtl/ffe_pkg.sv - shared types and helpers for the FFE select mux
package ffe_pkg;

  localparam int DEF_DATA_WIDTH = 12;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ffe_mux_nx1_comb.sv
// rtl/ffe_mux_nx1_comb.sv - combinational N:1 slice selector
module ffe_mux_nx1_comb
  import ffe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_IN     = 4,
  parameter int SEL_W      = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]             i_sel,
  output logic [DATA_WIDTH-1:0]        o_data
);

  // Selects beyond NUM_IN yield zero rather than an out-of-bounds slice.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (i_sel == SEL_W'(i)) o_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/ffe_sel_mux_sync.sv
// rtl/ffe_sel_mux_sync.sv - registered N:1 channel selector with handshaked
// source switch and post-switch output blanking
module ffe_sel_mux_sync
  import ffe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_IN       = 4,
  parameter int BLANK_CYCLES = 3,
  localparam int SEL_W       = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         sel_req_valid,
  input  logic [SEL_W-1:0]             sel_req,
  output logic                         sel_req_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic [SEL_W-1:0]             cur_sel,
  output logic                         sel_err
);

  localparam int CNT_W = (clog2(BLANK_CYCLES + 1) < 1) ? 1 : clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  state_t                  r_state, w_nxt_state;
  logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;
  logic [SEL_W-1:0]        r_cur_sel, w_nxt_sel;
  logic [DATA_WIDTH-1:0]   r_out_data, w_nxt_data;
  logic                    r_out_valid, w_nxt_valid;
  logic                    r_sel_err, w_nxt_err;
  logic [DATA_WIDTH-1:0]   w_mux_data;
  logic                    w_accept;
  logic                    w_req_oor;

  ffe_mux_nx1_comb #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_IN     (NUM_IN),
    .SEL_W      (SEL_W)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (r_cur_sel),
    .o_data (w_mux_data)
  );

  assign sel_req_ready = (r_state == RUN);
  assign w_accept      = sel_req_valid & sel_req_ready;
  assign w_req_oor     = ({1'b0, sel_req} >= NUM_IN_L);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_sel   = r_cur_sel;
    w_nxt_data  = w_mux_data;
    w_nxt_valid = in_valid;
    w_nxt_err   = 1'b0;
    case (r_state)
      RUN: begin
        // The word registered on the accepting edge still comes from the old channel.
        if (w_accept) begin
          if (w_req_oor) begin
            w_nxt_err = 1'b1;
          end else if (sel_req != r_cur_sel) begin
            w_nxt_sel = sel_req;
            if (BLANK_CYCLES > 0) begin
              w_nxt_state = BLANK;
              w_nxt_cnt   = CNT_LOAD;
            end
          end
        end
      end
      BLANK: begin
        w_nxt_data  = '0;
        w_nxt_valid = 1'b0;
        if (r_cnt == '0) w_nxt_state = RUN;
        else             w_nxt_cnt   = r_cnt - CNT_W'(1);
      end
      default: w_nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_cur_sel   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_cur_sel   <= w_nxt_sel;
      r_out_data  <= w_nxt_data;
      r_out_valid <= w_nxt_valid;
      r_sel_err   <= w_nxt_err;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign cur_sel   = r_cur_sel;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_ffe_sel_mux_sync.sv
// tb/tb_ffe_sel_mux_sync.sv - scoreboard bench for ffe_sel_mux_sync
module tb_ffe_sel_mux_sync;

  typedef struct {
    int         unit;
    logic [11:0] data;
    logic       valid;
    logic [1:0] sel;
    logic       rdy;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // unit 0: 4 ch, blank 3; unit 1: 3 ch, blank 3; unit 2: 4 ch, blank 0
  logic [47:0] din_a = {12'h444, 12'h333, 12'h222, 12'h111};
  logic [35:0] din_b = {12'h333, 12'h222, 12'h111};
  logic [47:0] din_c = {12'h444, 12'h333, 12'h222, 12'h111};
  logic        v_a = 1'b1, v_b = 1'b1, v_c = 1'b1;
  logic        rv_a = 1'b0, rv_b = 1'b0, rv_c = 1'b0;
  logic [1:0]  rq_a = '0, rq_b = '0, rq_c = '0;

  logic        rdy_a, rdy_b, rdy_c;
  logic [11:0] od_a, od_b, od_c;
  logic        ov_a, ov_b, ov_c;
  logic [1:0]  cs_a, cs_b, cs_c;
  logic        er_a, er_b, er_c;

  ffe_sel_mux_sync #(.DATA_WIDTH(12), .NUM_IN(4), .BLANK_CYCLES(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(din_a), .in_valid(v_a),
    .sel_req_valid(rv_a), .sel_req(rq_a), .sel_req_ready(rdy_a),
    .out_data(od_a), .out_valid(ov_a), .cur_sel(cs_a), .sel_err(er_a)
  );

  ffe_sel_mux_sync #(.DATA_WIDTH(12), .NUM_IN(3), .BLANK_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(din_b), .in_valid(v_b),
    .sel_req_valid(rv_b), .sel_req(rq_b), .sel_req_ready(rdy_b),
    .out_data(od_b), .out_valid(ov_b), .cur_sel(cs_b), .sel_err(er_b)
  );

  ffe_sel_mux_sync #(.DATA_WIDTH(12), .NUM_IN(4), .BLANK_CYCLES(0)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(din_c), .in_valid(v_c),
    .sel_req_valid(rv_c), .sel_req(rq_c), .sel_req_ready(rdy_c),
    .out_data(od_c), .out_valid(ov_c), .cur_sel(cs_c), .sel_err(er_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic cyc(input int u, input logic [11:0] d, input logic v,
                     input logic [1:0] s, input logic r, input logic e);
    exp_t x;
    logic [11:0] gd;
    logic gv, gr, ge;
    logic [1:0] gs;
    x.unit = u; x.data = d; x.valid = v; x.sel = s; x.rdy = r; x.err = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    case (x.unit)
      0:       begin gd = od_a; gv = ov_a; gs = cs_a; gr = rdy_a; ge = er_a; end
      1:       begin gd = od_b; gv = ov_b; gs = cs_b; gr = rdy_b; ge = er_b; end
      default: begin gd = od_c; gv = ov_c; gs = cs_c; gr = rdy_c; ge = er_c; end
    endcase
    check($sformatf("u%0d.out_data", x.unit),  32'(gd), 32'(x.data));
    check($sformatf("u%0d.out_valid", x.unit), 32'(gv), 32'(x.valid));
    check($sformatf("u%0d.cur_sel", x.unit),   32'(gs), 32'(x.sel));
    check($sformatf("u%0d.ready", x.unit),     32'(gr), 32'(x.rdy));
    check($sformatf("u%0d.sel_err", x.unit),   32'(ge), 32'(x.err));
  endtask

  initial begin
    // reset state of every unit
    cyc(0, 12'h000, 0, 0, 1, 0);
    cyc(1, 12'h000, 0, 0, 1, 0);
    cyc(2, 12'h000, 0, 0, 1, 0);
    rst = 1'b0;

    // steady state, then in_valid low still updates data
    cyc(0, 12'h111, 1, 0, 1, 0);
    v_a = 1'b0;
    cyc(0, 12'h111, 0, 0, 1, 0);
    v_a = 1'b1;
    cyc(0, 12'h111, 1, 0, 1, 0);

    // switch to 2 with a three-cycle blank
    rv_a = 1'b1; rq_a = 2'd2;
    cyc(0, 12'h111, 1, 2, 0, 0);
    rv_a = 1'b0;
    cyc(0, 12'h000, 0, 2, 0, 0);
    cyc(0, 12'h000, 0, 2, 0, 0);
    cyc(0, 12'h000, 0, 2, 1, 0);
    cyc(0, 12'h333, 1, 2, 1, 0);

    // same-select request: no blanking
    rv_a = 1'b1; rq_a = 2'd2;
    cyc(0, 12'h333, 1, 2, 1, 0);
    rv_a = 1'b0;
    cyc(0, 12'h333, 1, 2, 1, 0);

    // switch to 0, then a request for 3 held through the blank window
    rv_a = 1'b1; rq_a = 2'd0;
    cyc(0, 12'h333, 1, 0, 0, 0);
    rq_a = 2'd3;
    cyc(0, 12'h000, 0, 0, 0, 0);
    cyc(0, 12'h000, 0, 0, 0, 0);
    cyc(0, 12'h000, 0, 0, 1, 0);
    cyc(0, 12'h111, 1, 3, 0, 0);
    rv_a = 1'b0;
    cyc(0, 12'h000, 0, 3, 0, 0);
    cyc(0, 12'h000, 0, 3, 0, 0);
    cyc(0, 12'h000, 0, 3, 1, 0);
    cyc(0, 12'h444, 1, 3, 1, 0);

    // reset on the second blank cycle
    rv_a = 1'b1; rq_a = 2'd1;
    cyc(0, 12'h444, 1, 1, 0, 0);
    rv_a = 1'b0;
    cyc(0, 12'h000, 0, 1, 0, 0);
    rst = 1'b1;
    cyc(0, 12'h000, 0, 0, 1, 0);
    rst = 1'b0;
    cyc(0, 12'h111, 1, 0, 1, 0);

    // out-of-range select on a 3-channel unit
    cyc(1, 12'h111, 1, 0, 1, 0);
    rv_b = 1'b1; rq_b = 2'd3;
    cyc(1, 12'h111, 1, 0, 1, 1);
    rv_b = 1'b0;
    cyc(1, 12'h111, 1, 0, 1, 0);
    rv_b = 1'b1; rq_b = 2'd2;
    cyc(1, 12'h111, 1, 2, 0, 0);
    rv_b = 1'b0;
    cyc(1, 12'h000, 0, 2, 0, 0);
    cyc(1, 12'h000, 0, 2, 0, 0);
    cyc(1, 12'h000, 0, 2, 1, 0);
    cyc(1, 12'h333, 1, 2, 1, 0);

    // zero-blank unit with toggling in_valid
    cyc(2, 12'h111, 1, 0, 1, 0);
    rv_c = 1'b1; rq_c = 2'd1; v_c = 1'b0;
    cyc(2, 12'h111, 0, 1, 1, 0);
    rv_c = 1'b0; v_c = 1'b1;
    cyc(2, 12'h222, 1, 1, 1, 0);
    v_c = 1'b0;
    cyc(2, 12'h222, 0, 1, 1, 0);
    v_c = 1'b1;
    cyc(2, 12'h222, 1, 1, 1, 0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ffe_sel_mux_sync.md
Name: ffe_sel_mux_sync

Overview:
Registered N:1 data-path selector for the FFE equalizer. It picks one of NUM_IN sample/coefficient channels and drives it to the downstream tap pipeline. A source change uses a valid/ready handshake, so the select switches only on an accepted request. After each real switch, the output is blanked for a programmable number of cycles so the downstream taps flush stale samples. Out-of-range select requests are rejected and flagged.

Parameters:
DATA_WIDTH, 12, width of each channel word.
NUM_IN, 4, number of input channels (>=2).
BLANK_CYCLES, 3, cycles of forced-zero, invalid output after a select change (0 = no blanking).
SEL_W (localparam), clog2(NUM_IN), select width (min 1).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_data  in  NUM_IN*DATA_WIDTH  packed channels; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH].
in_valid  in  1  qualifies in_data this cycle.
sel_req_valid  in  1  select change request.
sel_req  in  SEL_W  requested channel.
sel_req_ready  out  1  high when a request can be accepted.
out_data  out  DATA_WIDTH  registered selected word.
out_valid  out  1  registered qualifier.
cur_sel  out  SEL_W  channel currently in effect.
sel_err  out  1  one-cycle pulse: rejected out-of-range request.

Behaviour:
- Reset (synchronous, any state, including mid-blank):
  - out_data=0, out_valid=0, cur_sel=0, sel_err=0.
  - State=RUN, blank counter=0.
  - sel_req_ready=1 in the cycle after the reset edge.
- States: RUN, BLANK. sel_req_ready = (state==RUN), combinational.
- RUN, each edge:
  - out_data <= channel[cur_sel].
  - out_valid <= in_valid.
  - Latency is 1 cycle.
  - out_data updates even when in_valid=0; its value is don't-care to consumers while out_valid=0.
- Accept = sel_req_valid & sel_req_ready, sampled at edge E. Cases at E:
  - sel_req >= NUM_IN: sel_err<=1 for one cycle, cur_sel unchanged, stay RUN. The data path continues normally.
  - sel_req == cur_sel: no-op, no blanking, sel_err stays 0.
  - Otherwise, with BLANK_CYCLES>0: cur_sel<=sel_req, counter<=BLANK_CYCLES-1, state<=BLANK. Output at E still uses the old channel.
  - Otherwise, with BLANK_CYCLES=0: cur_sel<=sel_req, stay RUN. The next edge outputs the new channel.
- BLANK, each edge:
  - out_data<=0, out_valid<=0, in_valid ignored.
  - If counter==0, state<=RUN; else counter decrements.
  - BLANK lasts exactly BLANK_CYCLES cycles. The first new-channel output is registered at edge E+BLANK_CYCLES+1.
- sel_req_valid during BLANK is not accepted. The requester must hold it; it is accepted on the first RUN cycle.
- sel_err is cleared to 0 on every edge without a rejected accept.
- Counter width is clog2(BLANK_CYCLES+1), minimum 1. No wrap: the counter never decrements below 0.
- Non-power-of-2 NUM_IN: any select value >= NUM_IN is out of range (e.g. NUM_IN=3, sel 3 rejected).

Decomposition:
- Package ffe_pkg holds:
  - the clog2 helper function;
  - the state enum (RUN=0, BLANK=1);
  - the default DATA_WIDTH constant (12).
- One natural sub-module: ffe_mux_nx1_comb, a purely combinational N:1 slice selector parametrised by DATA_WIDTH/NUM_IN. It is instantiated once; the handshake, FSM and output registers stay in the top.

Test Plan:
- Reset/steady state: NUM_IN=4, DATA_WIDTH=12, channels 0x111/0x222/0x333/0x444, in_valid=1 after reset → out_data=0x111, out_valid=1 one cycle later, cur_sel=0, sel_req_ready=1.
- Switch with blanking: sel_req=2 accepted at edge E, BLANK_CYCLES=3 → edge E outputs 0x111; edges E+1..E+3 output 0/valid 0 with ready=0; edge E+4 outputs 0x333/valid 1; cur_sel=2 from E.
- Out-of-range: NUM_IN=3, sel_req=3 → sel_err pulses one cycle, cur_sel unchanged, output uninterrupted with no blanking.
- Same-select and held request: sel_req=cur_sel → no blanking. A request held through BLANK is accepted on the first RUN cycle and starts a second blank window.
- Reset mid-BLANK: rst asserted on the 2nd blank cycle → next cycle cur_sel=0, state RUN, ready=1, outputs 0. The cycle after, 0x111 appears if in_valid=1.
- BLANK_CYCLES=0, in_valid toggling: switch 0→1 → next edge outputs 0x222. out_valid tracks in_valid with 1-cycle latency throughout.
